// File: rtl/exposure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exposure_ctrl
//  Purpose  : Saturating exposure-time register driven by debounced inc/dec
//             buttons, plus a one-shot exposure window generator that holds
//             expose high for exactly ex_time cycles and then pulses done.
//  Ports    :
//    clk      in   1  clock, all logic on rising edge
//    reset    in   1  synchronous active-high reset
//    init     in   1  reload ex_time with T_INIT (idle only)
//    Exp_inc  in   1  increase request (level)
//    Exp_dec  in   1  decrease request (level)
//    start    in   1  begin an exposure window (idle only)
//    ex_time  out  W  current exposure time setting
//    expose   out  1  high during the exposure window
//    busy     out  1  high in EXPOSE and DONE
//    done     out  1  one-cycle strobe at end of exposure
//  Revision : 1.0  initial release
// ============================================================================
module exposure_ctrl #(
  parameter int W      = 5,
  parameter int T_MIN  = 2,
  parameter int T_MAX  = 30,
  parameter int T_INIT = 15,
  parameter int STEP   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         Exp_inc,
  input  logic         Exp_dec,
  input  logic         start,
  output logic [W-1:0] ex_time,
  output logic         expose,
  output logic         busy,
  output logic         done
);

  // Constants widened to W+1 bits so adjustment math never wraps.
  localparam logic [W:0]   C_MIN_X   = (W+1)'(T_MIN);
  localparam logic [W:0]   C_MAX_X   = (W+1)'(T_MAX);
  localparam logic [W:0]   C_STEP_X  = (W+1)'(STEP);
  localparam logic [W:0]   C_FLOOR_X = (W+1)'(T_MIN + STEP);
  localparam logic [W-1:0] C_INIT    = W'(T_INIT);
  localparam logic [W-1:0] C_MIN     = W'(T_MIN);
  localparam logic [W-1:0] C_MAX     = W'(T_MAX);
  localparam logic [W-1:0] C_ONE     = W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPOSE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] ex_time_q;
  logic [W-1:0] ex_time_d;
  logic [W-1:0] cnt_q;
  logic         inc_prev_q;
  logic         dec_prev_q;
  logic         expose_q;
  logic         busy_q;
  logic         done_q;

  logic         inc_edge;
  logic         dec_edge;
  logic [W:0]   ex_ext;
  logic [W:0]   ex_sum;
  logic [W:0]   ex_diff;

  // Button-driven next value of ex_time; only applied from IDLE when
  // neither init nor start is asserted.
  always_comb begin
    inc_edge  = Exp_inc & ~inc_prev_q;
    dec_edge  = Exp_dec & ~dec_prev_q;
    ex_ext    = {1'b0, ex_time_q};
    ex_sum    = ex_ext + C_STEP_X;
    ex_diff   = ex_ext - C_STEP_X;
    ex_time_d = ex_time_q;
    if (inc_edge && !dec_edge) begin
      ex_time_d = (ex_sum > C_MAX_X) ? C_MAX : ex_sum[W-1:0];
    end else if (dec_edge && !inc_edge) begin
      // Compare before subtracting so a small ex_time cannot underflow.
      ex_time_d = (ex_ext < C_FLOOR_X) ? C_MIN : ex_diff[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ex_time_q  <= C_INIT;
      cnt_q      <= '0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      expose_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Edge history follows the inputs in every state, so a button held
      // through an exposure does not count as a press afterwards.
      inc_prev_q <= Exp_inc;
      dec_prev_q <= Exp_dec;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (init) begin
            ex_time_q <= C_INIT;
          end else if (start) begin
            state_q  <= S_EXPOSE;
            cnt_q    <= ex_time_q;
            expose_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            ex_time_q <= ex_time_d;
          end
        end
        S_EXPOSE: begin
          if (cnt_q == C_ONE) begin
            state_q  <= S_DONE;
            expose_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - C_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          expose_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ex_time = ex_time_q;
  assign expose  = expose_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_exposure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exposure_ctrl
//  Purpose  : Scoreboard bench for exposure_ctrl; expected {ex_time, expose,
//             busy, done} tuples are queued as stimulus is applied and
//             popped after each clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exposure_ctrl;

  typedef struct packed {
    logic [4:0] ex;
    logic       ep;
    logic       bz;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, init, Exp_inc, Exp_dec, start;
  logic [4:0] ex_time;
  logic       expose, busy, done;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   m_ex  = 15;

  always #5 clk = ~clk;

  exposure_ctrl #(.W(5), .T_MIN(2), .T_MAX(30), .T_INIT(15), .STEP(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .Exp_inc (Exp_inc),
    .Exp_dec (Exp_dec),
    .start   (start),
    .ex_time (ex_time),
    .expose  (expose),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; init = 1'b0; Exp_inc = 1'b0; Exp_dec = 1'b0; start = 1'b0;
    tick();
    tick();
    sb.push_back({5'd15, 1'b0, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({ex_time, expose, busy, done} !== e) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {ex_time, expose, busy, done}, e);
    end
    reset = 1'b0;
    m_ex = 15;
    for (int k = 0; k < 3; k++) begin
      sb.push_back({5'd15, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL post_reset_idle[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
  endtask

  task automatic test_sat_up;
    for (int i = 0; i < 20; i++) begin
      Exp_inc = 1'b1;
      m_ex = (m_ex + 1 > 30) ? 30 : m_ex + 1;
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL sat_up[%0d] got=%h want=%h", i, {ex_time, expose, busy, done}, e);
      end
      Exp_inc = 1'b0;
      tick();
    end
  endtask

  task automatic test_sat_down;
    for (int i = 0; i < 40; i++) begin
      Exp_dec = 1'b1;
      m_ex = (m_ex - 1 < 2) ? 2 : m_ex - 1;
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL sat_down[%0d] got=%h want=%h", i, {ex_time, expose, busy, done}, e);
      end
      Exp_dec = 1'b0;
      tick();
    end
  endtask

  task automatic test_held_and_both;
    // Held increment: one step only.
    Exp_inc = 1'b1;
    m_ex = m_ex + 1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL held_inc[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
    Exp_inc = 1'b0;
    tick();
    // Simultaneous rising edges: no change.
    Exp_inc = 1'b1;
    Exp_dec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL both_edges[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
    Exp_inc = 1'b0;
    Exp_dec = 1'b0;
    tick();
  endtask

  task automatic test_init;
    init = 1'b1;
    Exp_inc = 1'b1;
    m_ex = 15;
    sb.push_back({5'd15, 1'b0, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    total++;
    if ({ex_time, expose, busy, done} !== e) begin
      bad++;
      $display("FAIL init_reload got=%h want=%h", {ex_time, expose, busy, done}, e);
    end
    init = 1'b0;
    Exp_inc = 1'b0;
    tick();
  endtask

  task automatic test_exposure;
    int ep_cnt;
    // Walk down to 7.
    while (m_ex > 7) begin
      Exp_dec = 1'b1;
      m_ex = m_ex - 1;
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL setup7 got=%h want=%h", {ex_time, expose, busy, done}, e);
      end
      Exp_dec = 1'b0;
      tick();
    end
    ep_cnt = 0;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) Exp_inc = 1'b1;
      if (k == 5) Exp_inc = 1'b0;
      sb.push_back({5'd7, (k < 7), (k < 8), (k == 7)});
      tick();
      start = 1'b0;
      if (expose) ep_cnt++;
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL exposure[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
    total++;
    if (ep_cnt !== 7) begin
      bad++;
      $display("FAIL expose_len got=%0d want=7", ep_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int p;
    start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      p = k % 9;
      sb.push_back({5'd7, (p < 7), (p < 8), (p == 7)});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL b2b[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back({5'd7, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL b2b_tail[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    while (m_ex < 20) begin
      Exp_inc = 1'b1;
      m_ex = m_ex + 1;
      sb.push_back({5'(m_ex), 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL setup20 got=%h want=%h", {ex_time, expose, busy, done}, e);
      end
      Exp_inc = 1'b0;
      tick();
    end
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sb.push_back({5'd20, 1'b1, 1'b1, 1'b0});
      tick();
      start = 1'b0;
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL mid_expose[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
    reset = 1'b1;
    m_ex = 15;
    sb.push_back({5'd15, 1'b0, 1'b0, 1'b0});
    tick();
    reset = 1'b0;
    e = sb.pop_front();
    total++;
    if ({ex_time, expose, busy, done} !== e) begin
      bad++;
      $display("FAIL abort got=%h want=%h", {ex_time, expose, busy, done}, e);
    end
    for (int k = 0; k < 20; k++) begin
      sb.push_back({5'd15, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      total++;
      if ({ex_time, expose, busy, done} !== e) begin
        bad++;
        $display("FAIL after_abort[%0d] got=%h want=%h", k, {ex_time, expose, busy, done}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sat_up();
    test_sat_down();
    test_held_and_both();
    test_init();
    test_exposure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
